// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: two valid/ready sources plus one registered valid/ready output with mux select
interface mux2_rr_arbiter_if #(parameter int DATA_W = 8);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-channel round-robin burst arbiter with registered output beat and mux select
module mux2_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  mux2_rr_arbiter_if.slave     io_bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [7:0] CNT_LAST = 8'(BURST - 1);
  state_t            r_state, w_state_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic              r_last, w_last_nx;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sel;
  logic              w_space, w_gx, w_vx, w_vo, w_xfer, w_exit;
  assign w_space = !r_out_valid || io_bus.out_ready;
  assign w_gx    = r_state == GNT1;
  assign w_vx    = w_gx ? io_bus.in1_valid : io_bus.in0_valid;
  assign w_vo    = w_gx ? io_bus.in0_valid : io_bus.in1_valid;
  assign w_xfer  = r_state != IDLE && w_vx && w_space;
  // a grant ends when its source drops valid or its last allowed beat transfers
  assign w_exit  = r_state != IDLE && (!w_vx || (w_xfer && r_cnt == CNT_LAST));
  assign io_bus.in0_ready = r_state == GNT0 && w_space;
  assign io_bus.in1_ready = r_state == GNT1 && w_space;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_sel   = r_out_sel;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_last_nx  = r_last;
    if (r_state == IDLE) begin
      w_cnt_nx = '0;
      if (io_bus.in0_valid && (!io_bus.in1_valid || r_last)) w_state_nx = GNT0;
      else if (io_bus.in1_valid) w_state_nx = GNT1;
    end else if (w_exit) begin
      w_cnt_nx   = '0;
      w_last_nx  = w_gx;
      w_state_nx = w_vo ? (w_gx ? GNT0 : GNT1) : w_vx ? r_state : IDLE;
    end else if (w_xfer) begin
      w_cnt_nx = r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_last  <= w_last_nx;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gx ? io_bus.in1_data : io_bus.in0_data;
        r_out_sel   <= w_gx;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: randomized and directed checks of BURST=4 and BURST=1 arbiters against a beat-level model
module tb_mux2_rr_arbiter;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic v0 = 0, v1 = 0, ordy = 0;
  logic [7:0] d0 = 0, d1 = 0;
  int n_cmp = 0, n_bad = 0;
  mux2_rr_arbiter_if #(.DATA_W(8)) bus_a ();
  mux2_rr_arbiter_if #(.DATA_W(8)) bus_b ();
  assign bus_a.in0_valid = v0;
  assign bus_a.in0_data  = d0;
  assign bus_a.in1_valid = v1;
  assign bus_a.in1_data  = d1;
  assign bus_a.out_ready = ordy;
  assign bus_b.in0_valid = v0;
  assign bus_b.in0_data  = d0;
  assign bus_b.in1_valid = v1;
  assign bus_b.in1_data  = d1;
  assign bus_b.out_ready = ordy;
  logic ov[2], os[2], r0[2], r1[2];
  logic [7:0] od[2];
  assign ov[0] = bus_a.out_valid;
  assign os[0] = bus_a.out_sel;
  assign od[0] = bus_a.out_data;
  assign r0[0] = bus_a.in0_ready;
  assign r1[0] = bus_a.in1_ready;
  assign ov[1] = bus_b.out_valid;
  assign os[1] = bus_b.out_sel;
  assign od[1] = bus_b.out_data;
  assign r0[1] = bus_b.in0_ready;
  assign r1[1] = bus_b.in1_ready;
  mux2_rr_arbiter #(.DATA_W(8), .BURST(4)) u_b4 (.clk(clk), .rst_n(rst_n), .io_bus(bus_a.slave));
  mux2_rr_arbiter #(.DATA_W(8), .BURST(1)) u_b1 (.clk(clk), .rst_n(rst_n), .io_bus(bus_b.slave));
  // model: owner of the path (-1 none), beats taken in this grant, channel preferred on a tie
  int own[2], run[2], pref[2];
  int bur[2] = '{4, 1};
  logic m_ov[2], m_os[2];
  logic [7:0] m_od[2];
  function automatic logic erdy(int k, int ch);
    return own[k] == ch && (!m_ov[k] || ordy);
  endfunction
  task model_reset;
    for (int k = 0; k < 2; k++) begin
      own[k] = -1; run[k] = 0; pref[k] = 0; m_ov[k] = 0; m_os[k] = 0; m_od[k] = 0;
    end
  endtask
  task model_step;
    logic vx, vo, took;
    for (int k = 0; k < 2; k++) begin
      if (own[k] < 0) begin
        if (m_ov[k] && ordy) m_ov[k] = 0;
        if (v0 || v1) begin
          own[k] = (v0 && v1) ? pref[k] : (v0 ? 0 : 1);
          run[k] = 0;
        end
      end else begin
        vx = own[k] == 0 ? v0 : v1;
        vo = own[k] == 0 ? v1 : v0;
        took = vx && (!m_ov[k] || ordy);
        if (took) begin
          m_ov[k] = 1; m_od[k] = own[k] == 0 ? d0 : d1; m_os[k] = own[k] == 1; run[k]++;
        end else if (m_ov[k] && ordy) m_ov[k] = 0;
        if (!vx || (took && run[k] == bur[k])) begin
          pref[k] = 1 - own[k];
          run[k] = 0;
          own[k] = vo ? 1 - own[k] : (vx ? own[k] : -1);
        end
      end
    end
  endtask
  task tick;
    model_step();
    @(negedge clk);
  endtask
  task hard_reset;
    @(negedge clk);
    rst_n = 0; v0 = 0; v1 = 0; ordy = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task test_reset;
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ov[k], os[k], od[k], r0[k], r1[k]} !== 12'h000) begin
        n_bad++; $display("FAIL reset[b%0d] got %h want 000", k, {ov[k], os[k], od[k], r0[k], r1[k]});
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task test_reset_mid;
    v0 = 1; d0 = 8'h55; ordy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL pre_reset[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (i < 2) tick();
    end
    n_cmp++;
    if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL held_beat got %b want 1", ov[0]); end
    #1 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({ov[k], os[k], od[k], r0[k], r1[k]} !== 12'h000) begin
        n_bad++; $display("FAIL async_reset[b%0d] got %h want 000", k, {ov[k], os[k], od[k], r0[k], r1[k]});
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1; v0 = 0; v1 = 1; d1 = 8'h66; ordy = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) v1 = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL after_reset[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (i == 0) begin n_cmp++; if (r1[0] !== 1'b0) begin n_bad++; $display("FAIL idle_ready got %b want 0", r1[0]); end end
      if (i == 1) begin n_cmp++; if (r1[0] !== 1'b1) begin n_bad++; $display("FAIL gnt1_ready got %b want 1", r1[0]); end end
      if (i == 2) begin
        n_cmp++;
        if ({ov[0], os[0], od[0]} !== {1'b1, 1'b1, 8'h66}) begin n_bad++; $display("FAIL first_beat got v%b s%b d%h want v1 s1 d66", ov[0], os[0], od[0]); end
      end
      tick();
    end
  endtask
  task test_single_source;
    int sent, cyc;
    logic [7:0] got[$];
    logic acc;
    sent = 0; cyc = 0; v1 = 0; ordy = 1;
    while (sent < 10 && cyc < 30) begin
      v0 = 1; d0 = 8'h10 + 8'(sent);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL single[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (ov[0] && ordy) got.push_back(od[0]);
      acc = erdy(0, 0);
      tick();
      if (acc) sent++;
      cyc++;
    end
    v0 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ov[0] && ordy) got.push_back(od[0]);
      tick();
    end
    n_cmp++;
    if (cyc !== 11) begin n_bad++; $display("FAIL single_cycles got %0d want 11", cyc); end
    n_cmp++;
    if (got.size() !== 10) begin n_bad++; $display("FAIL single_count got %0d want 10", got.size()); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_cmp++;
      if (got[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL single_data[%0d] got %h want %h", i, got[i], 8'h10 + 8'(i)); end
    end
  endtask
  task test_contention;
    int n0, n1;
    logic s[$];
    logic a0, a1;
    hard_reset();
    n0 = 0; n1 = 0; v0 = 1; v1 = 1; ordy = 1;
    for (int i = 0; i < 18; i++) begin
      d0 = 8'hA0 + 8'(n0 % 16); d1 = 8'hB0 + 8'(n1 % 16);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL contention[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (ov[0]) s.push_back(os[0]);
      a0 = erdy(0, 0); a1 = erdy(0, 1);
      tick();
      if (a0) n0++;
      if (a1) n1++;
    end
    n_cmp++;
    if (s.size() !== 16) begin n_bad++; $display("FAIL contention_count got %0d want 16", s.size()); end
    for (int i = 0; i < s.size(); i++) begin
      n_cmp++;
      if (s[i] !== 1'((i / 4) % 2)) begin n_bad++; $display("FAIL contention_sel[%0d] got %b want %b", i, s[i], 1'((i / 4) % 2)); end
    end
    v0 = 0; v1 = 0;
    for (int i = 0; i < 3; i++) tick();
  endtask
  task test_backpressure;
    int sent, cyc;
    logic [7:0] got[$];
    logic [7:0] hd;
    logic hs, acc;
    sent = 0; cyc = 0; v1 = 0; hd = 0; hs = 0;
    while (sent < 12 && cyc < 40) begin
      v0 = 1; d0 = 8'h40 + 8'(sent);
      ordy = !(cyc >= 5 && cyc < 10);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL backpressure[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (cyc == 5) begin hd = od[0]; hs = os[0]; end
      if (cyc > 5 && cyc < 10) begin
        n_cmp++;
        if ({ov[0], os[0], od[0], r0[0]} !== {1'b1, hs, hd, 1'b0}) begin
          n_bad++; $display("FAIL frozen[%0d] got v%b s%b d%h r%b want v1 s%b d%h r0", cyc, ov[0], os[0], od[0], r0[0], hs, hd);
        end
      end
      if (ov[0] && ordy) got.push_back(od[0]);
      acc = erdy(0, 0);
      tick();
      if (acc) sent++;
      cyc++;
    end
    v0 = 0; ordy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ov[0] && ordy) got.push_back(od[0]);
      tick();
    end
    n_cmp++;
    if (got.size() !== 12) begin n_bad++; $display("FAIL bp_count got %0d want 12", got.size()); end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      n_cmp++;
      if (got[i] !== 8'h40 + 8'(i)) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, got[i], 8'h40 + 8'(i)); end
    end
  endtask
  task test_early_release;
    hard_reset();
    v0 = 0; v1 = 1; d0 = 8'hC0; d1 = 8'hD0; ordy = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) v0 = 1;
      if (i == 3) v1 = 0;
      d0 = 8'hC0 + 8'(i); d1 = 8'hD0 + 8'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL early[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (i == 3) begin n_cmp++; if (r0[0] !== 1'b0) begin n_bad++; $display("FAIL early_r0_drop got %b want 0", r0[0]); end end
      if (i == 4) begin n_cmp++; if (r0[0] !== 1'b1) begin n_bad++; $display("FAIL early_r0_gnt got %b want 1", r0[0]); end end
      if (i == 5) begin
        n_cmp++;
        if ({ov[0], os[0], od[0]} !== {1'b1, 1'b0, 8'hC4}) begin n_bad++; $display("FAIL early_ch0_beat got v%b s%b d%h want v1 s0 dc4", ov[0], os[0], od[0]); end
      end
      tick();
    end
    v0 = 0;
    for (int i = 0; i < 3; i++) tick();
  endtask
  task test_burst1;
    logic s[$];
    hard_reset();
    v0 = 1; v1 = 1; ordy = 1;
    for (int i = 0; i < 12; i++) begin
      d0 = 8'(i); d1 = 8'h80 + 8'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL burst1[b%0d] got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      if (ov[1]) s.push_back(os[1]);
      tick();
    end
    n_cmp++;
    if (s.size() !== 10) begin n_bad++; $display("FAIL burst1_count got %0d want 10", s.size()); end
    for (int i = 0; i < s.size(); i++) begin
      n_cmp++;
      if (s[i] !== 1'(i % 2)) begin n_bad++; $display("FAIL burst1_sel[%0d] got %b want %b", i, s[i], 1'(i % 2)); end
    end
    v0 = 0; v1 = 0;
    for (int i = 0; i < 3; i++) tick();
  endtask
  task test_random;
    for (int i = 0; i < 500; i++) begin
      v0 = ($urandom % 4) != 0; v1 = ($urandom % 4) != 0;
      d0 = 8'($urandom); d1 = 8'($urandom);
      ordy = ($urandom % 3) != 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({ov[k], os[k], od[k], r0[k], r1[k]} !== {m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1)}) begin
          n_bad++; $display("FAIL random[b%0d] cyc %0d got v%b s%b d%h r%b%b want v%b s%b d%h r%b%b", k, i, ov[k], os[k], od[k], r0[k], r1[k], m_ov[k], m_os[k], m_od[k], erdy(k, 0), erdy(k, 1));
        end
      end
      tick();
    end
  endtask
  initial begin
    test_reset();
    test_reset_mid();
    test_single_source();
    test_contention();
    test_backpressure();
    test_early_release();
    test_burst1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
